// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one GCD datapath unit between two requesters.
// Round-robin arbitration in IDLE, a one-cycle start to the unit, a wait for
// the rising edge of its done (guarded by a watchdog), then a one-cycle
// response pulse to whichever requester was granted. All outputs are registered.
module gcd_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    output logic             resp_valid0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic             resp_valid1,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_error,
    output logic             resp_timeout,
    output logic             busy,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    input  logic             gcd_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;

    // last: requester granted most recently; owner: requester of the job in flight
    logic               last;
    logic               last_nx;
    logic               owner;
    logic               owner_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic               done_q;

    logic               gnt0_nx;
    logic               gnt1_nx;
    logic               resp_valid0_nx;
    logic               resp_valid1_nx;
    logic [WIDTH-1:0]   resp_result_nx;
    logic               resp_error_nx;
    logic               resp_timeout_nx;
    logic               busy_nx;
    logic               gcd_start_nx;
    logic [WIDTH-1:0]   gcd_a_nx;
    logic [WIDTH-1:0]   gcd_b_nx;

    logic               any_req;
    logic               winner;
    logic               completion;
    logic               timeout_hit;

    // A done level still high from an earlier job has done_q set, so only a
    // fresh rising edge counts as completion.
    assign any_req     = req0 | req1;
    assign winner      = (req0 & req1) ? ~last : req1;
    assign completion  = gcd_done & ~done_q;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // Next-state decode for the IDLE -> ISSUE -> WAIT -> RESP sequence
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (completion || timeout_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of every registered output and of the arbitration/watchdog state
    always_comb begin
        last_nx         = last;
        owner_nx        = owner;
        cnt_nx          = cnt;
        gnt0_nx         = 1'b0;
        gnt1_nx         = 1'b0;
        gcd_start_nx    = 1'b0;
        resp_valid0_nx  = 1'b0;
        resp_valid1_nx  = 1'b0;
        gcd_a_nx        = gcd_a;
        gcd_b_nx        = gcd_b;
        resp_result_nx  = resp_result;
        resp_error_nx   = resp_error;
        resp_timeout_nx = resp_timeout;
        busy_nx         = (state_nx != IDLE);
        case (state)
            IDLE: begin
                if (any_req) begin
                    last_nx      = winner;
                    owner_nx     = winner;
                    gnt0_nx      = ~winner;
                    gnt1_nx      = winner;
                    gcd_start_nx = 1'b1;
                    gcd_a_nx     = winner ? a1 : a0;
                    gcd_b_nx     = winner ? b1 : b0;
                end
            end
            ISSUE: begin
                cnt_nx = '0;
            end
            WAIT: begin
                if (completion) begin
                    resp_result_nx  = gcd_result;
                    resp_error_nx   = gcd_error;
                    resp_timeout_nx = 1'b0;
                    resp_valid0_nx  = ~owner;
                    resp_valid1_nx  = owner;
                end else if (timeout_hit) begin
                    resp_result_nx  = '0;
                    resp_error_nx   = 1'b1;
                    resp_timeout_nx = 1'b1;
                    resp_valid0_nx  = ~owner;
                    resp_valid1_nx  = owner;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // State, bookkeeping and output registers; reset discards any job in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last         <= 1'b1;
            owner        <= 1'b0;
            cnt          <= '0;
            done_q       <= 1'b0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            gcd_start    <= 1'b0;
            resp_valid0  <= 1'b0;
            resp_valid1  <= 1'b0;
            resp_result  <= '0;
            resp_error   <= 1'b0;
            resp_timeout <= 1'b0;
            busy         <= 1'b0;
            gcd_a        <= '0;
            gcd_b        <= '0;
        end else begin
            state        <= state_nx;
            last         <= last_nx;
            owner        <= owner_nx;
            cnt          <= cnt_nx;
            done_q       <= gcd_done;
            gnt0         <= gnt0_nx;
            gnt1         <= gnt1_nx;
            gcd_start    <= gcd_start_nx;
            resp_valid0  <= resp_valid0_nx;
            resp_valid1  <= resp_valid1_nx;
            resp_result  <= resp_result_nx;
            resp_error   <= resp_error_nx;
            resp_timeout <= resp_timeout_nx;
            busy         <= busy_nx;
            gcd_a        <= gcd_a_nx;
            gcd_b        <= gcd_b_nx;
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Testbench for gcd_arbiter: a behavioural GCD unit with fixed latency (or a
// hang mode that never signals done), a grant monitor that pushes expected
// responses into a scoreboard, and a response monitor that pops and compares.
module tb_gcd_arbiter;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;
    localparam int LAT     = 3;
    localparam int NORM    = LAT + 2;
    localparam int HUNG    = TIMEOUT + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0;
    logic             req1 = 1'b0;
    logic [WIDTH-1:0] a0 = '0;
    logic [WIDTH-1:0] b0 = '0;
    logic [WIDTH-1:0] a1 = '0;
    logic [WIDTH-1:0] b1 = '0;
    logic             gnt0, gnt1, resp_valid0, resp_valid1;
    logic [WIDTH-1:0] resp_result;
    logic             resp_error, resp_timeout, busy, gcd_start;
    logic [WIDTH-1:0] gcd_a, gcd_b;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_result;
    logic             gcd_error;

    gcd_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0), .resp_valid0(resp_valid0),
        .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1), .resp_valid1(resp_valid1),
        .resp_result(resp_result), .resp_error(resp_error), .resp_timeout(resp_timeout),
        .busy(busy), .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
        .gcd_done(gcd_done), .gcd_result(gcd_result), .gcd_error(gcd_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               who;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit               hang;
        logic [WIDTH-1:0] res;
        bit               err;
        bit               to;
        int               lat;
    } vec_t;

    typedef struct {
        int               who;
        logic [WIDTH-1:0] res;
        bit               err;
        bit               to;
        int               lat;
    } exp_t;

    exp_t             sbq[$];
    int               order[$];
    logic [WIDTH-1:0] pa[2];
    logic [WIDTH-1:0] pb[2];
    exp_t             pexp[2];
    int               jobs_left[2];
    bit               stub_hang = 1'b0;
    bit               prev_g[2];
    bit               after_resp = 1'b0;
    int               cyc = 0;
    int               start_cyc = 0;
    int               n_checks = 0;
    int               n_fail = 0;

    // Cycle counter used to measure grant-to-response latency
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] gcd_f(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural GCD unit: done pulses LAT cycles after start, never in hang mode
    logic [WIDTH-1:0] op_a, op_b;
    int               stub_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gcd_done   <= 1'b0;
            gcd_result <= '0;
            gcd_error  <= 1'b0;
            stub_cnt   <= 0;
            op_a       <= '0;
            op_b       <= '0;
        end else begin
            gcd_done <= 1'b0;
            if (gcd_start) begin
                op_a <= gcd_a;
                op_b <= gcd_b;
                if (!stub_hang) stub_cnt <= LAT;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    gcd_done <= 1'b1;
                    if (op_a == 0 || op_b == 0) begin
                        gcd_result <= '0;
                        gcd_error  <= 1'b1;
                    end else begin
                        gcd_result <= gcd_f(op_a, op_b);
                        gcd_error  <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_gnt0"}, gnt0, 0);
        checkOutput({tag, "_gnt1"}, gnt1, 0);
        checkOutput({tag, "_resp_valid0"}, resp_valid0, 0);
        checkOutput({tag, "_resp_valid1"}, resp_valid1, 0);
        checkOutput({tag, "_resp_result"}, resp_result, 0);
        checkOutput({tag, "_resp_error"}, resp_error, 0);
        checkOutput({tag, "_resp_timeout"}, resp_timeout, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_gcd_start"}, gcd_start, 0);
        checkOutput({tag, "_gcd_a"}, gcd_a, 0);
        checkOutput({tag, "_gcd_b"}, gcd_b, 0);
    endtask

    // Grant and response monitor: pushes expectations on grant, pops on response
    always @(negedge clk) begin
        if (!rst) begin
            if (after_resp) begin
                checkOutput("busy_after_resp", busy, 0);
                checkOutput("resp_valid_one_cycle", resp_valid0 | resp_valid1, 0);
                after_resp = 1'b0;
            end
            if (gcd_start) checkOutput("gcd_start_with_gnt", gnt0 | gnt1, 1);
            if (gnt0 || gnt1) checkOutput("gnt_onehot", gnt0 & gnt1, 0);
            for (int x = 0; x < 2; x++) begin
                if ((x == 0) ? gnt0 : gnt1) begin
                    checkOutput("gnt_pulse", prev_g[x], 0);
                    checkOutput("gnt_start", gcd_start, 1);
                    checkOutput("gnt_gcd_a", gcd_a, pa[x]);
                    checkOutput("gnt_gcd_b", gcd_b, pb[x]);
                    sbq.push_back(pexp[x]);
                    order.push_back(x);
                    start_cyc = cyc;
                    jobs_left[x]--;
                    if (jobs_left[x] <= 0) begin
                        if (x == 0) req0 = 1'b0;
                        else req1 = 1'b0;
                    end
                end
            end
            prev_g[0] = gnt0;
            prev_g[1] = gnt1;
            if (resp_valid0 || resp_valid1) begin
                checkOutput("resp_onehot", resp_valid0 & resp_valid1, 0);
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_resp: got resp_valid %0b%0b, expected none", resp_valid1, resp_valid0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput("resp_who", resp_valid1 ? 1 : 0, e.who);
                    checkOutput("resp_result", resp_result, e.res);
                    checkOutput("resp_error", resp_error, e.err);
                    checkOutput("resp_timeout", resp_timeout, e.to);
                    checkOutput("resp_latency", cyc - start_cyc, e.lat);
                end
                after_resp = 1'b1;
            end
        end
    end

    task automatic waitIdle(input string tag, input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            #1;
            if (!busy && sbq.size() == 0 && jobs_left[0] <= 0 && jobs_left[1] <= 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_idle_timeout: got busy=%0b pending=%0d, expected idle within %0d cycles", tag, busy, sbq.size(), max_cycles);
            req0 = 1'b0;
            req1 = 1'b0;
            jobs_left[0] = 0;
            jobs_left[1] = 0;
            sbq.delete();
        end
    endtask

    task automatic setJob(input vec_t v, input int count);
        pa[v.who]        = v.a;
        pb[v.who]        = v.b;
        pexp[v.who].who  = v.who;
        pexp[v.who].res  = v.res;
        pexp[v.who].err  = v.err;
        pexp[v.who].to   = v.to;
        pexp[v.who].lat  = v.lat;
        jobs_left[v.who] = count;
        if (v.who == 0) begin
            a0 = v.a;
            b0 = v.b;
        end else begin
            a1 = v.a;
            b1 = v.b;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        stub_hang = v.hang;
        setJob(v, 1);
        if (v.who == 0) req0 = 1'b1;
        else req1 = 1'b1;
        waitIdle("vector", 60);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkZero("reset");
        @(negedge clk);
        sbq.delete();
        order.delete();
        prev_g[0] = 1'b0;
        prev_g[1] = 1'b0;
        after_resp = 1'b0;
        rst = 1'b0;
    endtask

    vec_t vecs[6];
    vec_t va, vb;

    initial begin
        jobs_left[0] = 0;
        jobs_left[1] = 0;
        prev_g[0] = 1'b0;
        prev_g[1] = 1'b0;

        vecs[0] = '{who: 0, a: 12,  b: 18, hang: 0, res: 6,  err: 0, to: 0, lat: NORM};
        vecs[1] = '{who: 1, a: 0,   b: 3,  hang: 0, res: 0,  err: 1, to: 0, lat: NORM};
        vecs[2] = '{who: 0, a: 20,  b: 30, hang: 1, res: 0,  err: 1, to: 1, lat: HUNG};
        vecs[3] = '{who: 1, a: 100, b: 75, hang: 0, res: 25, err: 0, to: 0, lat: NORM};
        vecs[4] = '{who: 0, a: 17,  b: 17, hang: 0, res: 17, err: 0, to: 0, lat: NORM};
        vecs[5] = '{who: 1, a: 9,   b: 0,  hang: 0, res: 0,  err: 1, to: 0, lat: NORM};

        #1;
        checkZero("por");
        #20;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Simultaneous requests after reset: requester 0 wins the first tie
        doReset();
        va = '{who: 0, a: 48, b: 36, hang: 0, res: 12, err: 0, to: 0, lat: NORM};
        vb = '{who: 1, a: 7,  b: 5,  hang: 0, res: 1,  err: 0, to: 0, lat: NORM};
        @(negedge clk);
        stub_hang = 1'b0;
        setJob(va, 1);
        setJob(vb, 1);
        req0 = 1'b1;
        req1 = 1'b1;
        waitIdle("simul", 80);
        checkOutput("simul_grants", order.size(), 2);
        if (order.size() == 2) begin
            checkOutput("simul_first", order[0], 0);
            checkOutput("simul_second", order[1], 1);
        end

        // Both held high for two jobs each: grants alternate 0,1,0,1
        order.delete();
        @(negedge clk);
        setJob(va, 2);
        setJob(vb, 2);
        req0 = 1'b1;
        req1 = 1'b1;
        waitIdle("alternate", 120);
        checkOutput("alt_grants", order.size(), 4);
        if (order.size() == 4) begin
            for (int i = 0; i < 4; i++) checkOutput("alt_order", order[i], i % 2);
        end

        // Asynchronous reset in the middle of WAIT discards the job
        order.delete();
        @(negedge clk);
        stub_hang = 1'b1;
        setJob(vecs[2], 1);
        req0 = 1'b1;
        for (int i = 0; i < 20 && order.size() == 0; i++) @(negedge clk);
        checkOutput("midwait_granted", order.size(), 1);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkZero("midwait_rst");
        sbq.delete();
        order.delete();
        after_resp = 1'b0;
        prev_g[0] = 1'b0;
        prev_g[1] = 1'b0;
        stub_hang = 1'b0;
        jobs_left[0] = 0;
        req0 = 1'b0;
        setJob(vb, 1);
        req1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_gnt1", gnt1, 1);
        checkOutput("after_rst_no_gnt0", gnt0, 0);
        waitIdle("after_rst", 60);
        checkOutput("after_rst_grants", order.size(), 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
